// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl; the ovf flag exists only
// when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first.
// Latency: WIDTH cycles from accept edge to out_valid; one op per WIDTH+2 cycles max.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Optional SERIAL_ADD_OVF_EN adds ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s, fa_co;

    assign fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_co = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & carry_q) | (a_sh_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_co;
                // new sum bit enters at the MSB so bit 0 ends up at position 0
                res_d   = (res_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_d;
                    cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this final cycle
                    ovf_d   = carry_q ^ fa_co;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): latency, corner sums, hold, ignore, reset, throughput.
module tb_serial_add_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (at negedges) for out_valid; returns the number of cycles waited.
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic [7:0] es, input logic ec, input logic eo, input string tag);
        int n;
        bus.a = ia; bus.b = ib; bus.cin = ic; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(n);
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_sum"}, bus.sum, es);
        chk({tag, "_cout"}, bus.cout, ec);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, bus.ovf, eo);
`else
        if (eo === 1'bx) $display("note: unexpected x ovf expectation in %s", tag);
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_ovalid_drop"}, bus.out_valid, 0);
        chk({tag, "_iready_back"}, bus.in_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int acc;
        int prev;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rexp;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 8'h00);
        chk("rst_cout", bus.cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", bus.ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b1 ^ 1'b1, 1'b1, "op_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "op_ff_01");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "op_80_80");
        run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "op_ff_00_c1");

        // 0x12+0x34+1 = 0x47 while in_valid toggles with junk operands
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 8'($urandom_range(0, 255)); bus.b = 8'($urandom_range(0, 255)); bus.cin = 1'($urandom_range(0, 1));
            chk("run_in_ready_low", bus.in_ready, 0);
            @(negedge clk);
            n++;
        end
        chk("ign_latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a = 8'hFF; bus.b = 8'hFF;
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_sum", bus.sum, 8'h47);
            chk("hold_cout", bus.cout, 0);
            chk("hold_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", bus.in_ready, 1);
        chk("release_out_valid", bus.out_valid, 0);
        chk("idle_sum_held", bus.sum, 8'h47);
        bus.out_ready = 1'b0;

        // abort by reset after 3 RUN cycles
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_sum", bus.sum, 8'h00);
        chk("abort_cout", bus.cout, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

        // back-to-back with out_ready tied high: one op per 10 cycles
        bus.out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rexp = 9'(ra) + 9'(rb) + 9'(rc);
            bus.a = ra; bus.b = rb; bus.cin = rc; bus.in_valid = 1'b1;
            n = 0;
            while (!bus.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_ready_wait_ok", (n < 20), 1);
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            acc = cyc;
            if (i > 0) chk("b2b_period", acc - prev, 10);
            prev = acc;
            wait_out(n);
            chk("b2b_latency", n, 8);
            chk("b2b_sum", bus.sum, rexp[7:0]);
            chk("b2b_cout", bus.cout, rexp[8]);
        end
        @(negedge clk);
        chk("b2b_final_idle", bus.in_ready, 1);
        bus.out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that reuses one 1-bit full-adder slice to add two WIDTH-bit operands over WIDTH clock cycles, LSB first. It sits between an operand producer and a result consumer, trading area for latency, and is the sequencing companion to the ripple-carry adders in the arithmetic practice set. Both sides use valid/ready handshakes.

## Interface

Parameters:
- WIDTH, default 8. Operand and result width; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum, cout (and ovf) hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow flag; present only with SERIAL_ADD_OVF_EN.

## Operation

- Internal full-adder slice: s = x^y^c, co = (x&y)|(y&c)|(x&c).
- Internal state: a_sh and b_sh (WIDTH-bit shift registers), carry flop, result shift register, bit counter of clog2(WIDTH) bits, and FSM.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load a_sh=a, b_sh=b, carry=cin, counter=0, and go to RUN.
  - RUN: in_ready=0. Each cycle, apply the slice to a_sh[0], b_sh[0], carry; shift the result bit into the result register MSB (shift right); shift a_sh and b_sh right; set carry=co; increment counter.
    - On the cycle with counter==WIDTH-1, copy the completed result to sum, copy the final co to cout, and go to DONE.
  - DONE: out_valid=1. sum, cout, and ovf are stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE; a, b, and cin are sampled only at the accept edge.
- sum and cout update only on the RUN->DONE transition and hold their values otherwise, including in IDLE.
- Arithmetic is unsigned modulo 2^WIDTH; {cout,sum} = a+b+cin exactly.
- No abort input. Only rst_n terminates an operation.

## Timing

- Reset (asynchronous assert, any state): state=IDLE; in_ready=1 while rst_n is low and after release; out_valid=0; sum=0; cout=0; ovf=0; all internal registers are 0.
- Reset asserted mid-RUN or in DONE discards the operation; no partial result is visible.
- Accept at edge E0. RUN occupies the cycles after edges E0..E0+WIDTH-1. out_valid rises after edge E0+WIDTH, so latency is WIDTH cycles.
- Result transfer at edge E1 (out_valid&out_ready): out_valid=0 and in_ready=1 after E1.
  - The earliest next accept is edge E1+1; there is no same-cycle result/accept overlap.
  - Maximum throughput is one operation per WIDTH+2 cycles.
- If out_ready is already high when DONE is entered, the transfer occurs on the first DONE edge and out_valid is high for exactly 1 cycle.
- Back-pressure: DONE persists indefinitely with outputs unchanged.

## Configuration

- SERIAL_ADD_OVF_EN defined:
  - Adds the ovf port.
  - ovf = (carry into bit WIDTH-1) XOR cout, registered together with sum.
  - ovf has reset value 0 and the same hold rules as cout.
- SERIAL_ADD_OVF_EN undefined: no ovf port and no overflow logic. All other behaviour is identical.

## Test plan

- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0, ovf=1; out_valid is first high exactly 8 cycles after the accept edge.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, and cout stay constant and in_ready stays 0. Raise out_ready -> in_ready=1 on the following cycle.
- Toggle in_valid with new operands throughout RUN and DONE -> they are ignored and the result equals the first accepted operation.
- Assert rst_n=0 after 3 RUN cycles -> out_valid=0, sum=0x00, cout=0, and in_ready=1 immediately. After release, a=0x01, b=0x02, cin=0 -> sum=0x03.
- Randomised back-to-back operations with out_ready tied to 1 -> every result matches a+b+cin, with one operation per 10 cycles.
